// File: rtl/sram_1rw1r_req_ctrl.sv
// Valid/ready front-end for a 1RW+1R SRAM macro: drives macro strobes from accepted requests,
// captures read data one cycle after the macro samples, and returns it through per-port FIFOs.
module sram_1rw1r_req_ctrl #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned RSP_DEPTH  = 4
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  a_req_valid,
   output logic                  a_req_ready,
   input  logic                  a_req_write,
   input  logic [ADDR_WIDTH-1:0] a_req_addr,
   input  logic [DATA_WIDTH-1:0] a_req_wdata,
   output logic                  a_rsp_valid,
   input  logic                  a_rsp_ready,
   output logic [DATA_WIDTH-1:0] a_rsp_data,
   input  logic                  b_req_valid,
   output logic                  b_req_ready,
   input  logic [ADDR_WIDTH-1:0] b_req_addr,
   output logic                  b_rsp_valid,
   input  logic                  b_rsp_ready,
   output logic [DATA_WIDTH-1:0] b_rsp_data,
   output logic                  b_conflict,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   input  logic [DATA_WIDTH-1:0] sram_dout0,
   output logic                  sram_csb1,
   output logic [ADDR_WIDTH-1:0] sram_addr1,
   input  logic [DATA_WIDTH-1:0] sram_dout1
);

   localparam int unsigned       CntW     = $clog2(RSP_DEPTH + 1);
   localparam int unsigned       PtrW     = $clog2(RSP_DEPTH);
   localparam logic [CntW-1:0]   DepthCnt = CntW'(RSP_DEPTH);
   localparam logic [PtrW-1:0]   LastPtr  = PtrW'(RSP_DEPTH - 1);

   // Index 0 is port A, index 1 is port B.
   logic [1:0]            req_rdy;
   logic [1:0]            rsp_vld;
   logic [1:0]            pop;
   logic [1:0]            inflight_d;
   logic [1:0]            inflight_q;
   logic [DATA_WIDTH-1:0] push_data [2];
   logic [DATA_WIDTH-1:0] head_data [2];
   logic                  a_fire;
   logic                  b_fire;
   logic                  collide;

   assign push_data[0] = sram_dout0;
   assign push_data[1] = sram_dout1;
   assign pop          = {rsp_vld[1] & b_rsp_ready, rsp_vld[0] & a_rsp_ready};

   for (genvar p = 0; p < 2; p++) begin : g_port
      logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
      logic [PtrW-1:0]       wr_ptr_q;
      logic [PtrW-1:0]       rd_ptr_q;
      logic [CntW-1:0]       cnt_q;
      logic [CntW-1:0]       cnt_d;
      logic [CntW-1:0]       outstanding;
      logic                  push;

      // Data is valid on dout during the cycle after the macro sampled the read.
      assign push         = inflight_q[p];
      assign outstanding  = cnt_q + CntW'(inflight_q[p]);
      assign req_rdy[p]   = RST_N & (outstanding < DepthCnt);
      assign rsp_vld[p]   = RST_N & (cnt_q != '0);
      assign head_data[p] = mem_q[rd_ptr_q];

      always_comb begin
         cnt_d = cnt_q;
         if (push && !pop[p]) begin
            cnt_d = cnt_q + CntW'(1);
         end else if (!push && pop[p]) begin
            cnt_d = cnt_q - CntW'(1);
         end
      end

      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            cnt_q <= cnt_d;
            if (push) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
            if (pop[p]) rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
         end
      end

      always_ff @(posedge CLK) begin
         if (push) mem_q[wr_ptr_q] <= push_data[p];
      end

      always_ff @(posedge CLK) begin
         if (RST_N) begin
            assert (!(push && cnt_q == DepthCnt))
               else $error("response fifo %0d pushed while full", p);
         end
      end
   end

   // A has priority; an A write to B's address stalls B so the macro never sees the collision.
   assign a_fire     = a_req_valid & req_rdy[0];
   assign collide    = a_fire & a_req_write & b_req_valid & (b_req_addr == a_req_addr);
   assign b_fire     = b_req_valid & req_rdy[1] & ~collide;
   assign inflight_d = {b_fire, a_fire & ~a_req_write};

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         inflight_q <= '0;
      end else begin
         inflight_q <= inflight_d;
      end
   end

   always_comb begin
      a_req_ready = req_rdy[0];
      b_req_ready = req_rdy[1] & ~collide;
      b_conflict  = collide;
      a_rsp_valid = rsp_vld[0];
      b_rsp_valid = rsp_vld[1];
      a_rsp_data  = head_data[0];
      b_rsp_data  = head_data[1];
      sram_csb0   = ~a_fire;
      sram_web0   = ~(a_fire & a_req_write);
      sram_addr0  = a_fire ? a_req_addr : '0;
      sram_din0   = a_fire ? a_req_wdata : '0;
      sram_csb1   = ~b_fire;
      sram_addr1  = b_fire ? b_req_addr : '0;
   end

endmodule

// File: doc/sram_1rw1r_req_ctrl.md
Name: sram_1rw1r_req_ctrl

Overview:
- Request/response front-end that sits directly upstream of the 16x8 1RW+1R OpenRAM macro and drives its port-0 (RW) and port-1 (R) pins.
- Converts two valid/ready request streams into macro csb/web/addr/din strobes.
- Captures macro dout at the correct edge, before the macro's post-edge X hold window, and presents read data on per-port valid/ready response streams through small FIFOs.
- Blocks the same-cycle write/read address collision that the macro does not resolve.

Parameters:
- ADDR_WIDTH, 4, macro address width.
- DATA_WIDTH, 8, macro data width.
- RSP_DEPTH, 4, entries per response FIFO; minimum 2; at least 3 needed for one read per cycle.

Ports:
- CLK  in  1  single clock; the top level also ties macro clk0 and clk1 to it.
- RST_N  in  1  asynchronous, active-low reset.
- a_req_valid  in  1  port A request valid.
- a_req_ready  out  1  port A request accepted when valid&ready.
- a_req_write  in  1  1 = write, 0 = read.
- a_req_addr  in  ADDR_WIDTH  port A address.
- a_req_wdata  in  DATA_WIDTH  port A write data.
- a_rsp_valid  out  1  port A read data valid.
- a_rsp_ready  in  1  port A response consumer ready.
- a_rsp_data  out  DATA_WIDTH  port A read data.
- b_req_valid  in  1  port B read request valid.
- b_req_ready  out  1  port B request accepted.
- b_req_addr  in  ADDR_WIDTH  port B address.
- b_rsp_valid  out  1  port B read data valid.
- b_rsp_ready  in  1  port B consumer ready.
- b_rsp_data  out  DATA_WIDTH  port B read data.
- b_conflict  out  1  pulse: B stalled this cycle by an A write to the same address.
- sram_csb0  out  1  to macro csb0.
- sram_web0  out  1  to macro web0.
- sram_addr0  out  ADDR_WIDTH  to macro addr0.
- sram_din0  out  DATA_WIDTH  to macro din0.
- sram_dout0  in  DATA_WIDTH  from macro dout0.
- sram_csb1  out  1  to macro csb1.
- sram_addr1  out  ADDR_WIDTH  to macro addr1.
- sram_dout1  in  DATA_WIDTH  from macro dout1.

Behaviour:
- Reset: RST_N low asynchronously clears FIFOs, in-flight flags and counters. While RST_N is low, the following are forced combinationally: sram_csb0/1 = 1, sram_web0 = 1, addr/din = 0, a/b_req_ready = 0, a/b_rsp_valid = 0, b_conflict = 0.
- Reset mid-operation: in-flight reads are discarded, and no response appears after release.
- Macro drive: combinational from the accepted request in the same cycle.
  - A fire: sram_csb0 = 0, sram_web0 = ~a_req_write, sram_addr0 = a_req_addr, sram_din0 = a_req_wdata.
  - A idle: csb0 = 1, web0 = 1, addr0/din0 = 0.
  - Port B drive is analogous on csb1/addr1.
- Read timing: read accepted in cycle N, macro samples at the edge ending N, and dout is valid during N+1.
  - The controller sets an in-flight flag for N+1 and writes sram_doutX into the port FIFO at the edge ending N+1.
  - rsp_valid is first high in N+2. Latency is 2 cycles, with no bypass.
- Writes produce no response and never occupy FIFO space.
- Per-port outstanding = fifo_count + inflight (0..RSP_DEPTH).
  - a_req_ready = (outstanding_A < RSP_DEPTH) and not in reset; b is the same for port B.
  - Ready is taken from registered state only. There is no combinational path from rsp_ready to req_ready.
- Port A ready is independent of request type, so writes are also blocked when outstanding_A = RSP_DEPTH.
- Collision: if A fires a write and b_req_valid=1 and b_req_addr == a_req_addr in the same cycle:
  - b_req_ready = 0 and b_conflict = 1 for that cycle; A has priority.
  - B retries the next cycle and reads the new data.
  - An A read does not block B.
- Write-then-read: A write to X in cycle N followed by B read of X in N+1 returns the new data, since the macro writes at the negedge before the B sample.
- FIFOs: in-order push/pop; a simultaneous push and pop keeps the count unchanged.
  - Overflow is impossible by construction; an assertion must flag any push while full.
  - Pointers wrap modulo RSP_DEPTH (non-power-of-2 allowed).
- Response data is held stable while valid & ~ready.
- Ports A and B are fully independent apart from the collision rule.

Test Plan:
- Reset release, A write 0x5A to addr 3 then A read addr 3 -> a_rsp_valid exactly 2 cycles after read accept, a_rsp_data=0x5A; csb0 high while idle.
- A write addr 7=0xC3 and B read addr 7 in the same cycle -> b_req_ready=0, b_conflict=1 for 1 cycle; B accepted next cycle returns 0xC3.
- B streaming reads of addr 0..15 with b_rsp_ready=1, RSP_DEPTH=4 -> one acceptance per cycle, data in address order, no gaps.
- b_rsp_ready=0 with continuous B reads -> exactly 4 accepted, then b_req_ready=0; raising ready drains 4 in order and acceptance resumes.
- RST_N pulsed low while 2 A reads are in flight -> no a_rsp_valid after release, FIFO empty, a_req_ready=1 on the first cycle after release.
